// File: rtl/flash_sample_reader.sv
// ============================================================================
// Module : flash_sample_reader
// Brief  : Avalon-MM flash word fetcher that plays back one sample per start
//          request, forward or reverse, wrapping inside a word-address region.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module flash_sample_reader #(
  parameter int ADDR_W   = 23,
  parameter int DATA_W   = 32,
  parameter int SAMPLE_W = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                restart,
  input  logic                dir,
  input  logic [ADDR_W-1:0]   start_addr,
  input  logic [ADDR_W-1:0]   end_addr,
  output logic [ADDR_W-1:0]   flash_addr,
  output logic                flash_read,
  input  logic                flash_waitrequest,
  input  logic [DATA_W-1:0]   flash_readdata,
  input  logic                flash_readdatavalid,
  output logic [SAMPLE_W-1:0] sample_out,
  output logic                sample_valid,
  output logic                busy,
  output logic                wrapped
);

  localparam int NSAMP  = DATA_W / SAMPLE_W;
  localparam int SLOT_W = (NSAMP > 1) ? $clog2(NSAMP) : 1;
  localparam logic [SLOT_W-1:0] C_SLOT_LAST = SLOT_W'(NSAMP - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_EMIT = 2'd3
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_buf;
  logic                r_full;
  logic [SLOT_W-1:0]   r_slot;
  logic                r_wdir;
  logic                r_pending;
  logic [SAMPLE_W-1:0] r_sample;
  logic                r_valid;
  logic                r_wrapped;

  logic                w_read;
  logic                w_latch;
  logic                w_emit;
  logic                w_reload;
  logic                w_wrap;
  logic                w_last;
  logic [ADDR_W-1:0]   w_addr_adv;
  logic [SAMPLE_W-1:0] w_sel;

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // A restart seen during a bus transaction (now or earlier) turns the
  // returning word into a discard followed by the reload.
  always_comb begin
    w_next   = r_state;
    w_read   = 1'b0;
    w_latch  = 1'b0;
    w_emit   = 1'b0;
    w_reload = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (restart)    w_reload = 1'b1;
        else if (start) w_next   = r_full ? S_EMIT : S_REQ;
      end
      S_REQ: begin
        w_read = 1'b1;
        if (!flash_waitrequest) w_next = S_WAIT;
      end
      S_WAIT: begin
        if (flash_readdatavalid) begin
          if (r_pending || restart) begin
            w_reload = 1'b1;
            w_next   = S_IDLE;
          end else begin
            w_latch = 1'b1;
            w_next  = S_EMIT;
          end
        end
      end
      S_EMIT: begin
        w_emit = 1'b1;
        w_next = S_IDLE;
        if (r_pending || restart) w_reload = 1'b1;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_wrap = dir ? (r_addr == start_addr) : (r_addr == end_addr);
    if (dir) w_addr_adv = w_wrap ? end_addr   : r_addr - ADDR_W'(1);
    else     w_addr_adv = w_wrap ? start_addr : r_addr + ADDR_W'(1);
    w_last = r_wdir ? (r_slot == '0) : (r_slot == C_SLOT_LAST);
  end

  always_comb begin
    w_sel = '0;
    for (int i = 0; i < NSAMP; i++) begin
      if (r_slot == SLOT_W'(i)) w_sel = r_buf[i*SAMPLE_W +: SAMPLE_W];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_addr    <= '0;
      r_buf     <= '0;
      r_full    <= 1'b0;
      r_slot    <= '0;
      r_wdir    <= 1'b0;
      r_pending <= 1'b0;
      r_sample  <= '0;
      r_valid   <= 1'b0;
      r_wrapped <= 1'b0;
    end else begin
      r_valid   <= w_emit;
      r_wrapped <= 1'b0;
      if (w_latch) begin
        r_buf     <= flash_readdata;
        r_full    <= 1'b1;
        r_wdir    <= dir;
        r_slot    <= dir ? C_SLOT_LAST : '0;
        r_addr    <= w_addr_adv;
        r_wrapped <= w_wrap;
      end
      if (w_emit) begin
        r_sample <= w_sel;
        r_slot   <= r_wdir ? (r_slot - SLOT_W'(1)) : (r_slot + SLOT_W'(1));
        if (w_last) r_full <= 1'b0;
      end
      // Reload comes last so it overrides the emit-path buffer bookkeeping.
      if (w_reload) begin
        r_addr    <= dir ? end_addr : start_addr;
        r_full    <= 1'b0;
        r_pending <= 1'b0;
      end else if (restart && (r_state == S_REQ || r_state == S_WAIT)) begin
        r_pending <= 1'b1;
      end
    end
  end

  assign flash_read   = w_read;
  assign flash_addr   = r_addr;
  assign sample_out   = r_sample;
  assign sample_valid = r_valid;
  assign busy         = (r_state != S_IDLE);
  assign wrapped      = r_wrapped;

endmodule

`default_nettype wire

// File: tb/tb_flash_sample_reader.sv
// ============================================================================
// Module : tb_flash_sample_reader
// Brief  : Directed self-checking bench with a sample scoreboard queue.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_flash_sample_reader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        restart = 1'b0;
  logic        dir = 1'b0;
  logic [22:0] start_addr = '0;
  logic [22:0] end_addr = '0;
  logic [22:0] flash_addr;
  logic        flash_read;
  logic        flash_waitrequest = 1'b0;
  logic [31:0] flash_readdata = '0;
  logic        flash_readdatavalid = 1'b0;
  logic [15:0] sample_out;
  logic        sample_valid;
  logic        busy;
  logic        wrapped;

  int n_checks = 0;
  int n_fail   = 0;
  int n_valid  = 0;
  logic [15:0] sb_q[$];

  flash_sample_reader #(.ADDR_W(23), .DATA_W(32), .SAMPLE_W(16)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .start               (start),
    .restart             (restart),
    .dir                 (dir),
    .start_addr          (start_addr),
    .end_addr            (end_addr),
    .flash_addr          (flash_addr),
    .flash_read          (flash_read),
    .flash_waitrequest   (flash_waitrequest),
    .flash_readdata      (flash_readdata),
    .flash_readdatavalid (flash_readdatavalid),
    .sample_out          (sample_out),
    .sample_valid        (sample_valid),
    .busy                (busy),
    .wrapped             (wrapped)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (!rst && sample_valid) begin
      n_valid++;
      chk("sb_nonempty", 64'(sb_q.size() != 0), 64'd1);
      if (sb_q.size() != 0) chk("sample", 64'(sample_out), 64'(sb_q.pop_front()));
    end
  end

  // One fetch from start request through emission (or discard).
  task automatic fetch(input logic [22:0] ea, input int nwait, input int lat,
                       input logic [31:0] data, input bit emit, input bit wrap,
                       input bit rs_in_wait, input bit hold_start);
    start = 1'b1;
    flash_waitrequest = (nwait > 0);
    tick();
    if (!hold_start) start = 1'b0;
    for (int i = 0; i < nwait; i++) begin
      chk("req_read_wr", 64'(flash_read), 64'd1);
      chk("req_addr_wr", 64'(flash_addr), 64'(ea));
      tick();
    end
    flash_waitrequest = 1'b0;
    chk("req_read", 64'(flash_read), 64'd1);
    chk("req_addr", 64'(flash_addr), 64'(ea));
    tick();
    chk("wait_noread", 64'(flash_read), 64'd0);
    if (rs_in_wait) begin
      restart = 1'b1;
      tick();
      restart = 1'b0;
    end
    for (int i = 0; i < lat; i++) begin
      tick();
      chk("wait_noread_lat", 64'(flash_read), 64'd0);
    end
    flash_readdatavalid = 1'b1;
    flash_readdata = data;
    tick();
    flash_readdatavalid = 1'b0;
    chk("emit_cycle_novalid", 64'(sample_valid), 64'd0);
    chk("wrapped", 64'(wrapped), 64'(wrap));
    chk("busy_after_rdv", 64'(busy), 64'(emit));
    tick();
    if (hold_start) start = 1'b0;
    chk("valid_lat2", 64'(sample_valid), 64'(emit));
    chk("wrapped_pulse", 64'(wrapped), 64'd0);
  endtask

  task automatic emit_buffered();
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("buf_noread", 64'(flash_read), 64'd0);
    chk("buf_busy", 64'(busy), 64'd1);
    tick();
    chk("buf_valid_lat2", 64'(sample_valid), 64'd1);
    chk("buf_noread2", 64'(flash_read), 64'd0);
  endtask

  task automatic do_restart(input logic d);
    dir = d;
    restart = 1'b1;
    tick();
    restart = 1'b0;
    chk("restart_idle", 64'(busy), 64'd0);
  endtask

  initial begin
    int v0;
    // Reset state
    tick();
    tick();
    chk("rst_read", 64'(flash_read), 64'd0);
    chk("rst_addr", 64'(flash_addr), 64'd0);
    chk("rst_sample", 64'(sample_out), 64'd0);
    chk("rst_valid", 64'(sample_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_wrapped", 64'(wrapped), 64'd0);
    rst = 1'b0;
    start_addr = 23'h10;
    end_addr   = 23'h12;

    // Forward playback with wrap
    do_restart(1'b0);
    sb_q.push_back(16'hAAAA); fetch(23'h10, 0, 0, 32'hBBBB_AAAA, 1, 0, 0, 0);
    sb_q.push_back(16'hBBBB); emit_buffered();
    sb_q.push_back(16'hAAAA); fetch(23'h11, 0, 0, 32'hBBBB_AAAA, 1, 0, 0, 0);
    sb_q.push_back(16'hBBBB); emit_buffered();
    sb_q.push_back(16'hAAAA); fetch(23'h12, 0, 0, 32'hBBBB_AAAA, 1, 1, 0, 0);
    sb_q.push_back(16'hBBBB); emit_buffered();
    sb_q.push_back(16'hAAAA); fetch(23'h10, 0, 0, 32'hBBBB_AAAA, 1, 0, 0, 0);

    // Reverse playback with wrap
    do_restart(1'b1);
    sb_q.push_back(16'hBBBB); fetch(23'h12, 0, 0, 32'hBBBB_AAAA, 1, 0, 0, 0);
    sb_q.push_back(16'hAAAA); emit_buffered();
    sb_q.push_back(16'hBBBB); fetch(23'h11, 0, 0, 32'hBBBB_AAAA, 1, 0, 0, 0);
    sb_q.push_back(16'hAAAA); emit_buffered();
    sb_q.push_back(16'hBBBB); fetch(23'h10, 0, 0, 32'hBBBB_AAAA, 1, 1, 0, 0);
    sb_q.push_back(16'hAAAA); emit_buffered();
    sb_q.push_back(16'hBBBB); fetch(23'h12, 0, 0, 32'hBBBB_AAAA, 1, 0, 0, 0);

    // Waitrequest stall and read latency, then buffered second sample
    do_restart(1'b0);
    sb_q.push_back(16'h1111); fetch(23'h10, 5, 3, 32'h2222_1111, 1, 0, 0, 0);
    sb_q.push_back(16'h2222); emit_buffered();

    // Restart during WAIT discards the word and reloads start_addr
    fetch(23'h11, 0, 1, 32'hDEAD_BEEF, 0, 0, 1, 0);
    sb_q.push_back(16'h3333); fetch(23'h10, 0, 0, 32'h4444_3333, 1, 0, 0, 0);
    sb_q.push_back(16'h4444); emit_buffered();

    // Reset during WAIT, then a stray readdatavalid
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    chk("in_wait", 64'(busy), 64'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    flash_readdatavalid = 1'b1;
    flash_readdata = 32'hFFFF_EEEE;
    tick();
    flash_readdatavalid = 1'b0;
    tick();
    tick();
    chk("stray_read", 64'(flash_read), 64'd0);
    chk("stray_addr", 64'(flash_addr), 64'd0);
    chk("stray_sample", 64'(sample_out), 64'd0);
    chk("stray_valid", 64'(sample_valid), 64'd0);
    chk("stray_busy", 64'(busy), 64'd0);
    chk("stray_wrapped", 64'(wrapped), 64'd0);

    // Simultaneous restart+start: start dropped
    dir = 1'b0;
    restart = 1'b1;
    start = 1'b1;
    tick();
    restart = 1'b0;
    start = 1'b0;
    chk("rs_start_busy", 64'(busy), 64'd0);
    tick();
    chk("rs_start_noread", 64'(flash_read), 64'd0);
    chk("rs_start_busy2", 64'(busy), 64'd0);

    // Start held while busy yields exactly one sample
    v0 = n_valid;
    sb_q.push_back(16'hAAAA); fetch(23'h10, 2, 2, 32'hBBBB_AAAA, 1, 0, 0, 1);
    tick();
    tick();
    tick();
    chk("one_valid", 64'(n_valid - v0), 64'd1);
    chk("sb_drained", 64'(sb_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
